// File: rtl/axis_reg_pipe_pkg.sv
// axis_reg_pipe_pkg: shared stage-mode encoding and occupancy width helper
package axis_reg_pipe_pkg;
    typedef enum logic [1:0] {REG_BYPASS = 2'd0, REG_FULL = 2'd1, REG_FWD = 2'd2} reg_mode_e;
    function automatic int occ_bits(input int n);
        return n == 0 ? 1 : $clog2(2 * n + 1);
    endfunction
endpackage

// File: rtl/axis_reg_stage.sv
// axis_reg_stage: one AXI4-Stream register slice (bypass, full skid or forward-only)
module axis_reg_stage
    import axis_reg_pipe_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int REG_MODE  = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
);
    localparam int PW = DATA_BITS + DATA_BITS / 8 + 1;
    logic [PW-1:0] s_beat;
    assign s_beat = {s_tlast, s_tkeep, s_tdata};
    generate
        if (REG_MODE == int'(REG_FULL)) begin : g_full
            logic [PW-1:0] main_q, skid_q;
            logic main_v, skid_v, rdy, s_acc, load;
            assign s_acc = s_tvalid && rdy;
            assign load  = !main_v || m_tready;
            // rdy mirrors "skid empty" one cycle late, so it never depends on m_tready combinationally
            always_ff @(posedge aclk) begin
                if (areset) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                    rdy    <= 1'b0;
                end else if (load) begin
                    main_v <= skid_v || s_acc;
                    skid_v <= 1'b0;
                    rdy    <= 1'b1;
                end else if (s_acc) begin
                    skid_v <= 1'b1;
                    rdy    <= 1'b0;
                end
            end
            always_ff @(posedge aclk) begin
                if (load) main_q <= skid_v ? skid_q : s_beat;
                else if (s_acc) skid_q <= s_beat;
            end
            assign s_tready = rdy;
            assign m_tvalid = main_v;
            assign {m_tlast, m_tkeep, m_tdata} = main_q;
        end else if (REG_MODE == int'(REG_FWD)) begin : g_fwd
            logic [PW-1:0] q;
            logic v;
            assign s_tready = !v || m_tready;
            always_ff @(posedge aclk) begin
                if (areset) v <= 1'b0;
                else if (s_tready) v <= s_tvalid;
            end
            always_ff @(posedge aclk) begin
                if (s_tready && s_tvalid) q <= s_beat;
            end
            assign m_tvalid = v;
            assign {m_tlast, m_tkeep, m_tdata} = q;
        end else begin : g_byp
            assign s_tready = m_tready;
            assign m_tvalid = s_tvalid;
            assign {m_tlast, m_tkeep, m_tdata} = s_beat;
        end
    endgenerate
endmodule

// File: rtl/axis_reg_pipe.sv
// axis_reg_pipe: cascade of N_STAGES AXI4-Stream register slices with
// boundary occupancy and accepted-beat counters
module axis_reg_pipe
    import axis_reg_pipe_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int N_STAGES  = 2,
    parameter int REG_MODE  = 1,
    localparam int OCC_BITS = occ_bits(N_STAGES)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [OCC_BITS-1:0]    occupancy,
    output logic [31:0]            beat_cnt
);
    localparam int KB  = DATA_BITS / 8;
    localparam bit BYP = (REG_MODE == int'(REG_BYPASS)) || (N_STAGES == 0);
    logic s_acc, m_acc;
    generate
        if (BYP) begin : g_byp
            assign m_axis_tdata  = s_axis_tdata;
            assign m_axis_tkeep  = s_axis_tkeep;
            assign m_axis_tlast  = s_axis_tlast;
            assign m_axis_tvalid = s_axis_tvalid;
            assign s_axis_tready = m_axis_tready;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] d [N_STAGES+1];
            logic [KB-1:0]        k [N_STAGES+1];
            logic                 l [N_STAGES+1];
            logic                 v [N_STAGES+1];
            logic                 r [N_STAGES+1];
            assign d[0] = s_axis_tdata;
            assign k[0] = s_axis_tkeep;
            assign l[0] = s_axis_tlast;
            assign v[0] = s_axis_tvalid;
            assign s_axis_tready = r[0];
            assign m_axis_tdata  = d[N_STAGES];
            assign m_axis_tkeep  = k[N_STAGES];
            assign m_axis_tlast  = l[N_STAGES];
            assign m_axis_tvalid = v[N_STAGES];
            assign r[N_STAGES]   = m_axis_tready;
            for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
                axis_reg_stage #(.DATA_BITS(DATA_BITS), .REG_MODE(REG_MODE)) u_stage (
                    .aclk    (aclk),
                    .areset  (areset),
                    .s_tdata (d[i]),
                    .s_tkeep (k[i]),
                    .s_tlast (l[i]),
                    .s_tvalid(v[i]),
                    .s_tready(r[i]),
                    .m_tdata (d[i+1]),
                    .m_tkeep (k[i+1]),
                    .m_tlast (l[i+1]),
                    .m_tvalid(v[i+1]),
                    .m_tready(r[i+1])
                );
            end
        end
    endgenerate
    assign s_acc = s_axis_tvalid && s_axis_tready;
    assign m_acc = m_axis_tvalid && m_axis_tready;
    // one counter at the boundary tracks total beats in flight across every stage
    always_ff @(posedge aclk) begin
        if (areset) begin
            occupancy <= '0;
            beat_cnt  <= '0;
        end else begin
            beat_cnt  <= beat_cnt + 32'(s_acc);
            occupancy <= BYP ? '0 : occupancy + OCC_BITS'(s_acc) - OCC_BITS'(m_acc);
        end
    end
endmodule

// File: tb/tb_axis_reg_pipe.sv
// tb_axis_reg_pipe: queue-model scoreboard for the main pipe plus directed
// fill/drain and pass-through checks on the other configurations
module tb_axis_reg_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    logic [31:0] s0_d = '0, m0_d, cnt0;
    logic [3:0]  s0_k = '0, m0_k;
    logic        s0_l = 1'b0, s0_v = 1'b0, s0_r, m0_l, m0_v, m0_r = 1'b0;
    logic [2:0]  occ0;

    logic [31:0] xd = '0;
    logic [3:0]  xk = '0;
    logic        xl = 1'b0, xv = 1'b0, xr = 1'b0;
    logic [31:0] md [1:4];
    logic [3:0]  mk [1:4];
    logic        ml [1:4];
    logic        mv [1:4];
    logic        sr [1:4];
    logic [31:0] cn [1:4];
    logic [2:0]  occ1, occ2, occ3;
    logic [0:0]  occ4;

    axis_reg_pipe #(.DATA_BITS(32), .N_STAGES(2), .REG_MODE(1)) u0 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s0_d), .s_axis_tkeep(s0_k), .s_axis_tlast(s0_l), .s_axis_tvalid(s0_v), .s_axis_tready(s0_r),
        .m_axis_tdata(m0_d), .m_axis_tkeep(m0_k), .m_axis_tlast(m0_l), .m_axis_tvalid(m0_v), .m_axis_tready(m0_r),
        .occupancy(occ0), .beat_cnt(cnt0));
    axis_reg_pipe #(.DATA_BITS(32), .N_STAGES(3), .REG_MODE(1)) u1 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(xd), .s_axis_tkeep(xk), .s_axis_tlast(xl), .s_axis_tvalid(xv), .s_axis_tready(sr[1]),
        .m_axis_tdata(md[1]), .m_axis_tkeep(mk[1]), .m_axis_tlast(ml[1]), .m_axis_tvalid(mv[1]), .m_axis_tready(xr),
        .occupancy(occ1), .beat_cnt(cn[1]));
    axis_reg_pipe #(.DATA_BITS(32), .N_STAGES(2), .REG_MODE(2)) u2 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(xd), .s_axis_tkeep(xk), .s_axis_tlast(xl), .s_axis_tvalid(xv), .s_axis_tready(sr[2]),
        .m_axis_tdata(md[2]), .m_axis_tkeep(mk[2]), .m_axis_tlast(ml[2]), .m_axis_tvalid(mv[2]), .m_axis_tready(xr),
        .occupancy(occ2), .beat_cnt(cn[2]));
    axis_reg_pipe #(.DATA_BITS(32), .N_STAGES(2), .REG_MODE(0)) u3 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(xd), .s_axis_tkeep(xk), .s_axis_tlast(xl), .s_axis_tvalid(xv), .s_axis_tready(sr[3]),
        .m_axis_tdata(md[3]), .m_axis_tkeep(mk[3]), .m_axis_tlast(ml[3]), .m_axis_tvalid(mv[3]), .m_axis_tready(xr),
        .occupancy(occ3), .beat_cnt(cn[3]));
    axis_reg_pipe #(.DATA_BITS(32), .N_STAGES(0), .REG_MODE(1)) u4 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(xd), .s_axis_tkeep(xk), .s_axis_tlast(xl), .s_axis_tvalid(xv), .s_axis_tready(sr[4]),
        .m_axis_tdata(md[4]), .m_axis_tkeep(mk[4]), .m_axis_tlast(ml[4]), .m_axis_tvalid(mv[4]), .m_axis_tready(xr),
        .occupancy(occ4), .beat_cnt(cn[4]));

    // model: beats in flight are exactly the accepted-but-not-emitted queue
    logic [36:0] q0[$], q1[$], q2[$];
    logic [31:0] mc = '0;
    logic        stall = 1'b0;
    bit          run0 = 1'b0;
    int          acc_n = 0;

    logic [31:0] e_d [5] = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    bit          e_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          e_o [5] = '{1, 2, 2, 1, 0};

    always @(negedge clk) begin
        if (run0) begin
            if (m0_v) begin
                if (q0.size() == 0) chk("spurious_beat", m0_v, 0);
                else chk("m_beat", {m0_l, m0_k, m0_d}, q0[0]);
            end else if (stall) begin
                chk("hold_valid", m0_v, 1);
            end
            chk("occupancy", occ0, q0.size());
            chk("beat_cnt", cnt0, mc);
        end
    end

    task automatic step0(input logic v, input logic [36:0] b, input logic mr);
        logic rb;
        #2;
        rb = s0_r;
        s0_v = v;
        {s0_l, s0_k, s0_d} = b;
        m0_r = mr;
        #1;
        chk("ready_registered", s0_r, rb);
        if (m0_v && m0_r && q0.size() > 0) void'(q0.pop_front());
        if (s0_v && s0_r) begin
            q0.push_back(b);
            mc++;
            acc_n++;
        end
        stall = m0_v && !m0_r;
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        #2;
        rst = 1'b1;
        s0_v = 1'b0;
        xv = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        mc = '0;
        stall = 1'b0;
        @(negedge clk);
        chk("rst_ready", s0_r, 0);
        chk("rst_mvalid", m0_v, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_cnt", cnt0, 0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", s0_r, 1);
    endtask

    task automatic drain0();
        for (int i = 0; i < 20 && q0.size() > 0; i++) step0(1'b0, '0, 1'b1);
        chk("drain_empty", q0.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        v, acc;
        logic [36:0] b;
        int          base, cyc, prev, t, byp_acc;
        @(negedge clk);
        rst_pulse();
        run0 = 1'b1;
        // 0x11/0x22/0x33 back to back: presented in cycle c, visible in cycle c+2
        for (int i = 0; i < 5; i++) begin
            step0(i < 3, {1'(i == 2), 4'hF, 32'(32'h11 * (i + 1))}, 1'b1);
            chk("lat_valid", m0_v, e_v[i]);
            if (e_v[i]) chk("lat_data", m0_d, e_d[i]);
            chk("lat_occ", occ0, e_o[i]);
        end
        // reset with three beats held mid-packet, then a fresh packet
        for (int i = 0; i < 3; i++) step0(1'b1, {1'b0, 4'h3, 32'(32'hA0 + i)}, 1'b0);
        chk("mid_occ", occ0, 3);
        rst_pulse();
        for (int i = 0; i < 3; i++) step0(1'b1, {1'(i == 2), 4'hF, 32'(32'hB0 + i)}, 1'b1);
        drain0();
        // random valid/ready, source holds a beat until it is taken
        base = acc_n;
        cyc = 0;
        v = 1'b0;
        b = '0;
        acc = 1'b1;
        while (acc_n - base < 10000 && cyc < 60000) begin
            if (!v || acc) begin
                v = 1'($urandom_range(0, 1));
                b = {1'((acc_n - base) % 7 == 6), 4'($urandom), $urandom};
            end
            prev = acc_n;
            step0(v, b, 1'($urandom_range(0, 1)));
            acc = acc_n != prev;
            cyc++;
        end
        chk("random_beats", acc_n - base, 10000);
        drain0();
        // beat counter wrap from a preloaded value
        #1;
        force u0.beat_cnt = 32'hFFFF_FFFE;
        #1;
        release u0.beat_cnt;
        mc = 32'hFFFF_FFFE;
        @(negedge clk);
        step0(1'b1, {1'b0, 4'hF, 32'hC0}, 1'b1);
        chk("wrap_1", cnt0, 32'hFFFF_FFFF);
        step0(1'b1, {1'b0, 4'hF, 32'hC1}, 1'b1);
        chk("wrap_2", cnt0, 32'h0);
        step0(1'b1, {1'b1, 4'hF, 32'hC2}, 1'b1);
        chk("wrap_3", cnt0, 32'h1);
        drain0();
        run0 = 1'b0;
        // pass-through configurations
        byp_acc = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            xv = 1'($urandom);
            xr = 1'($urandom);
            xd = $urandom;
            xk = 4'($urandom);
            xl = 1'($urandom);
            #1;
            for (int j = 3; j <= 4; j++) begin
                chk("byp_beat", {ml[j], mk[j], md[j]}, {xl, xk, xd});
                chk("byp_valid", mv[j], xv);
                chk("byp_ready", sr[j], xr);
            end
            if (xv && xr) byp_acc++;
            @(negedge clk);
            chk("byp_occ3", occ3, 0);
            chk("byp_occ4", occ4, 0);
        end
        chk("byp_cnt3", cn[3], byp_acc);
        chk("byp_cnt4", cn[4], byp_acc);
        rst_pulse();
        // fill with downstream stalled
        xr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #2;
            xv = 1'b1;
            xd = 32'h100 + i;
            xk = 4'hF;
            xl = (i % 6 == 5);
            #1;
            if (xv && sr[1]) q1.push_back({xl, xk, xd});
            if (xv && sr[2]) q2.push_back({xl, xk, xd});
            @(negedge clk);
        end
        chk("fill_acc_full", q1.size(), 6);
        chk("fill_acc_fwd", q2.size(), 2);
        chk("fill_ready_full", sr[1], 0);
        chk("fill_ready_fwd", sr[2], 0);
        chk("fill_occ_full", occ1, 6);
        chk("fill_occ_fwd", occ2, 2);
        chk("fill_cnt_full", cn[1], 6);
        chk("fill_cnt_fwd", cn[2], 2);
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            #2;
            xv = 1'b0;
            xr = 1'b1;
            #1;
            if (mv[1]) begin
                if (q1.size() == 0) chk("drain_spurious_full", mv[1], 0);
                else chk("drain_full", {ml[1], mk[1], md[1]}, q1.pop_front());
            end
            if (mv[2]) begin
                if (q2.size() == 0) chk("drain_spurious_fwd", mv[2], 0);
                else chk("drain_fwd", {ml[2], mk[2], md[2]}, q2.pop_front());
            end
            @(negedge clk);
            if (sr[1] && t == 0) t = i;
        end
        chk("ready_back_within_3", (t >= 1 && t <= 3), 1);
        chk("drain_left_full", q1.size(), 0);
        chk("drain_left_fwd", q2.size(), 0);
        chk("drain_occ_full", occ1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
